// File: rtl/spi_sched_pkg.sv
// Shared types and default constants for the spi_master capture scheduler.
package spi_sched_pkg;

    localparam int WORD_W          = 32;
    localparam int DEF_POLL_PERIOD = 3900;
    localparam int DEF_RST_CYCLES  = 2;
    localparam int DEF_TIMEOUT     = 96;
    localparam int DEF_FIFO_DEPTH  = 4;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RST     = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4
    } sched_state_e;

endpackage

// File: rtl/sched_word_fifo.sv
// Synchronous word FIFO with occupancy level; head word is visible combinationally from storage.
// Latency: push visible at head one cycle later; push on full is refused unless a pop occurs in the same cycle.
module sched_word_fifo
    import spi_sched_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    push_vld,
    input  word_t                   push_dat,
    input  logic                    pop_rdy,
    output word_t                   head_dat,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int AW = $clog2(DEPTH);

    word_t         mem_q [DEPTH];
    word_t         mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          push_en;
    logic          pop_en;

    assign empty    = (level_q == '0);
    assign full     = (level_q == (AW+1)'(DEPTH));
    assign pop_en   = pop_rdy & ~empty;
    // A pop in the same cycle frees the slot the push needs.
    assign push_en  = push_vld & (~full | pop_en);
    assign head_dat = mem_q[rd_ptr_q];
    assign level    = level_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_en) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_en, pop_en})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/spi_capture_sched.sv
// Periodically runs a reset/start/capture sequence on spi_master and buffers captured words.
// Latency: spi_start RST_CYCLES+1 after trig, word_valid 2 cycles after spi_done; full FIFO drops the word and flags overflow.
module spi_capture_sched
    import spi_sched_pkg::*;
#(
    parameter int POLL_PERIOD = DEF_POLL_PERIOD,
    parameter int RST_CYCLES  = DEF_RST_CYCLES,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          enable,
    input  logic                          clear_err,
    output logic                          spi_rstn,
    output logic                          spi_start,
    input  logic                          spi_busy,
    input  logic                          spi_done,
    input  logic [WORD_W-1:0]             spi_data,
    output logic [WORD_W-1:0]             word_data,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          timeout_err,
    output logic                          overrun_err,
    output logic                          overflow_err
);

    localparam int PER_W  = $clog2(POLL_PERIOD);
    localparam int TMO_W  = $clog2(TIMEOUT);
    localparam int RSTC_W = $clog2(RST_CYCLES + 1);

    sched_state_e      state_q, state_d;
    logic [PER_W-1:0]  per_cnt_q, per_cnt_d;
    logic              trig_q, trig_d;
    logic [RSTC_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    word_t             cap_dat_q, cap_dat_d;
    logic              spi_rstn_q, spi_rstn_d;
    logic              spi_start_q, spi_start_d;
    logic              tmo_err_q, tmo_err_d;
    logic              ovr_err_q, ovr_err_d;
    logic              ovf_err_q, ovf_err_d;
    logic              push_vld;
    logic              tmo_evt, ovr_evt, ovf_evt;
    logic              fifo_empty, fifo_full, fifo_pop;
    logic              spi_busy_unused;

    // Busy is informational only; sequencing relies on done and the timeout.
    assign spi_busy_unused = spi_busy;

    always_comb begin
        per_cnt_d = per_cnt_q;
        trig_d    = 1'b0;
        if (!enable) begin
            per_cnt_d = '0;
        end else if (per_cnt_q == PER_W'(POLL_PERIOD - 1)) begin
            per_cnt_d = '0;
            trig_d    = 1'b1;
        end else begin
            per_cnt_d = per_cnt_q + 1'b1;
        end
    end

    assign fifo_pop = word_ready & ~fifo_empty;

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        cap_dat_d = cap_dat_q;
        push_vld  = 1'b0;
        tmo_evt   = 1'b0;
        ovf_evt   = 1'b0;
        ovr_evt   = trig_q & (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (trig_q) begin
                    state_d   = ST_RST;
                    rst_cnt_d = '0;
                end
            end
            ST_RST: begin
                if (rst_cnt_q == RSTC_W'(RST_CYCLES - 1)) begin
                    state_d = ST_START;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            ST_START: begin
                tmo_cnt_d = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                // Done takes priority, so a done on the last counted cycle is still captured.
                if (spi_done) begin
                    cap_dat_d = spi_data;
                    state_d   = ST_CAPTURE;
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                    tmo_evt = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_CAPTURE: begin
                push_vld = 1'b1;
                ovf_evt  = fifo_full & ~fifo_pop;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        spi_rstn_d  = (state_d != ST_RST);
        spi_start_d = (state_d == ST_START);
    end

    // A new error event outranks a simultaneous clear.
    always_comb begin
        tmo_err_d = tmo_evt ? 1'b1 : (clear_err ? 1'b0 : tmo_err_q);
        ovr_err_d = ovr_evt ? 1'b1 : (clear_err ? 1'b0 : ovr_err_q);
        ovf_err_d = ovf_evt ? 1'b1 : (clear_err ? 1'b0 : ovf_err_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            per_cnt_q   <= '0;
            trig_q      <= 1'b0;
            rst_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            cap_dat_q   <= '0;
            spi_rstn_q  <= 1'b0;
            spi_start_q <= 1'b0;
            tmo_err_q   <= 1'b0;
            ovr_err_q   <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            per_cnt_q   <= per_cnt_d;
            trig_q      <= trig_d;
            rst_cnt_q   <= rst_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            cap_dat_q   <= cap_dat_d;
            spi_rstn_q  <= spi_rstn_d;
            spi_start_q <= spi_start_d;
            tmo_err_q   <= tmo_err_d;
            ovr_err_q   <= ovr_err_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

    sched_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push_vld (push_vld),
        .push_dat (cap_dat_q),
        .pop_rdy  (word_ready),
        .head_dat (word_data),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .level    (fifo_level)
    );

    assign word_valid   = ~fifo_empty;
    assign spi_rstn     = spi_rstn_q;
    assign spi_start    = spi_start_q;
    assign timeout_err  = tmo_err_q;
    assign overrun_err  = ovr_err_q;
    assign overflow_err = ovf_err_q;

endmodule

// File: tb/tb_spi_capture_sched.sv
// Directed bench for spi_capture_sched with a behavioural spi_master slave whose done delay is programmable.
module tb_spi_capture_sched;

    localparam int P   = 130;
    localparam int RC  = 2;
    localparam int TMO = 150;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic        clear_err;
    logic        spi_rstn;
    logic        spi_start;
    logic        spi_busy = 1'b0;
    logic        spi_done = 1'b0;
    logic [31:0] spi_data = 32'h0;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_ready;
    logic [2:0]  fifo_level;
    logic        timeout_err;
    logic        overrun_err;
    logic        overflow_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int          slave_delay = 80;
    bit          slave_mute = 1'b0;
    logic [31:0] slave_word = 32'hDEADBEEF;
    int          sl_cnt = 0;

    int start_cnt = 0;
    int done_cnt = 0;
    int last_start = 0;
    int prev_start = 0;
    int low_run = 0;
    int last_low = 0;

    spi_capture_sched #(
        .POLL_PERIOD (P),
        .RST_CYCLES  (RC),
        .TIMEOUT     (TMO),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .enable       (enable),
        .clear_err    (clear_err),
        .spi_rstn     (spi_rstn),
        .spi_start    (spi_start),
        .spi_busy     (spi_busy),
        .spi_done     (spi_done),
        .spi_data     (spi_data),
        .word_data    (word_data),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .fifo_level   (fifo_level),
        .timeout_err  (timeout_err),
        .overrun_err  (overrun_err),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    // Slave: done pulses slave_delay cycles after the start cycle; data is garbage except on done.
    always @(posedge clk) begin
        #1;
        spi_done = 1'b0;
        spi_data = ~slave_word;
        if (!rstn) begin
            sl_cnt = 0;
        end else if (spi_start && !slave_mute) begin
            sl_cnt = slave_delay;
        end else if (sl_cnt > 0) begin
            sl_cnt = sl_cnt - 1;
            if (sl_cnt == 0) begin
                spi_done = 1'b1;
                spi_data = slave_word;
            end
        end
        spi_busy = (sl_cnt != 0);
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        #2;
        if (!rstn) begin
            low_run = 0;
        end else begin
            if (spi_start) begin
                prev_start = last_start;
                last_start = cyc;
                last_low   = low_run;
                start_cnt  = start_cnt + 1;
                low_run    = 0;
            end else if (!spi_rstn) begin
                low_run = low_run + 1;
            end else begin
                low_run = 0;
            end
            if (spi_done) done_cnt = done_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic wait_start();
        int s0 = start_cnt;
        int t = 0;
        while (start_cnt == s0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check1("start_seen", start_cnt != s0, 1'b1);
    endtask

    task automatic wait_done();
        int d0 = done_cnt;
        int t = 0;
        while (done_cnt == d0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check1("done_seen", done_cnt != d0, 1'b1);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pop1();
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
    endtask

    initial begin
        int          en_cyc;
        int          s;
        logic [31:0] drain_exp [4];
        drain_exp = '{32'd2, 32'd3, 32'd4, 32'd6};

        rstn       = 1'b0;
        enable     = 1'b0;
        clear_err  = 1'b0;
        word_ready = 1'b0;
        repeat (3) @(negedge clk);

        check1("rst_spi_rstn", spi_rstn, 1'b0);
        check1("rst_spi_start", spi_start, 1'b0);
        check1("rst_word_valid", word_valid, 1'b0);
        check("rst_word_data", word_data, 32'h0);
        check("rst_fifo_level", 32'(fifo_level), 32'd0);
        check("rst_err_flags", 32'({timeout_err, overrun_err, overflow_err}), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check1("spi_rstn_released", spi_rstn, 1'b1);

        // Normal capture
        enable = 1'b1;
        en_cyc = cyc;
        wait_start();
        check("first_start_cycle", last_start, en_cyc + P + RC + 1);
        check("rst_low_width", last_low, RC);
        wait_done();
        @(negedge clk);
        check1("valid_done_plus1", word_valid, 1'b0);
        @(negedge clk);
        check1("valid_done_plus2", word_valid, 1'b1);
        check("word_beef", word_data, 32'hDEADBEEF);
        check("level_one", 32'(fifo_level), 32'd1);
        pop1();
        check("level_after_pop", 32'(fifo_level), 32'd0);
        check1("valid_after_pop", word_valid, 1'b0);
        wait_start();
        check("start_period", last_start - prev_start, P);
        check("rst_low_width2", last_low, RC);
        wait_done();
        repeat (2) @(negedge clk);
        pop1();

        // Timeout, with enable dropped mid-transaction
        slave_mute = 1'b1;
        wait_start();
        s      = last_start;
        enable = 1'b0;
        wait_until(s + TMO - 1);
        check1("timeout_not_yet", timeout_err, 1'b0);
        wait_until(s + TMO + 1);
        check1("timeout_set", timeout_err, 1'b1);
        check("timeout_level", 32'(fifo_level), 32'd0);
        check1("timeout_no_overrun", overrun_err, 1'b0);
        slave_mute = 1'b0;
        pulse_clear();
        check1("timeout_cleared", timeout_err, 1'b0);
        slave_word = 32'd1;
        enable     = 1'b1;
        en_cyc     = cyc;
        wait_start();
        check("restart_after_timeout", last_start, en_cyc + P + RC + 1);

        // Overflow: five captures of 1..5, nothing popped
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) begin
                slave_word = 32'(k);
                wait_start();
            end
            wait_done();
            repeat (2) @(negedge clk);
            if (k == 4) begin
                check("level_full", 32'(fifo_level), 32'd4);
                check1("no_overflow_at_4", overflow_err, 1'b0);
            end
        end
        check("level_after_5", 32'(fifo_level), 32'd4);
        check1("overflow_set", overflow_err, 1'b1);
        check("head_is_first", word_data, 32'd1);

        // Push and pop in the same CAPTURE cycle while full
        pulse_clear();
        check1("overflow_cleared", overflow_err, 1'b0);
        slave_word = 32'd6;
        wait_start();
        wait_done();
        @(negedge clk);
        check("head_before_pushpop", word_data, 32'd1);
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
        check("level_pushpop", 32'(fifo_level), 32'd4);
        check1("no_overflow_pushpop", overflow_err, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("drain_order", word_data, drain_exp[k]);
            pop1();
        end
        check("level_drained", 32'(fifo_level), 32'd0);

        // Overrun: transaction still in WAIT when the next trigger fires
        slave_delay = 140;
        slave_word  = 32'hA5A50001;
        wait_start();
        s = last_start;
        wait_until(s + P);
        check1("overrun_set", overrun_err, 1'b1);
        wait_done();
        slave_delay = 80;
        repeat (2) @(negedge clk);
        check("overrun_word", word_data, 32'hA5A50001);
        check1("overrun_no_timeout", timeout_err, 1'b0);
        pop1();
        wait_start();
        check("overrun_trigger_skipped", last_start - prev_start, 2 * P);
        pulse_clear();
        check1("overrun_cleared", overrun_err, 1'b0);
        wait_done();
        repeat (2) @(negedge clk);

        // Reset in the middle of WAIT
        slave_word = 32'h0BADF00D;
        wait_start();
        repeat (10) @(negedge clk);
        check1("valid_before_reset", word_valid, 1'b1);
        rstn = 1'b0;
        #1;
        check1("midreset_spi_rstn", spi_rstn, 1'b0);
        check1("midreset_spi_start", spi_start, 1'b0);
        check1("midreset_word_valid", word_valid, 1'b0);
        check("midreset_level", 32'(fifo_level), 32'd0);
        repeat (2) @(negedge clk);
        rstn   = 1'b1;
        en_cyc = cyc;
        wait_start();
        check("resume_after_reset", last_start, en_cyc + P + RC + 1);
        wait_done();
        repeat (2) @(negedge clk);
        check("resume_word", word_data, 32'h0BADF00D);
        check("resume_level", 32'(fifo_level), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
